fetch_pc_unit: RTL and testbench

//  Instruction-fetch stage: owns the PC, selects the next PC, drives the instruction-memory

---
 rtl/fetch_pc_if.sv | 43 ++++
 rtl/fetch_pc_unit.sv | 115 +++++++++++
 tb/tb_fetch_pc_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fetch_pc_if.sv
// rtl/fetch_pc_if.sv - fetch stage bus bundle between EX/hazard/imem and the PC unit
// Purpose: groups the fetch-stage control, instruction-memory and IF/ID latch signals.
// Modports:
//   slave  - used by fetch_pc_unit (consumes Branch/Jump/TargetE/StallF/InstrF,
//            drives PCF and the IF/ID latch outputs)
//   master - used by the surrounding pipeline / bench (the opposite directions)
// Optional: FETCH_MISALIGN_TRAP_EN adds MisalignF.
interface fetch_pc_if #(
  parameter int XLEN = 32
);
  logic            Branch;
  logic            Jump;
  logic [XLEN-1:0] TargetE;
  logic            StallF;
  logic [XLEN-1:0] InstrF;
  logic [XLEN-1:0] PCF;
  logic [XLEN-1:0] InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic            ValidD;
  logic [15:0]     RedirectCnt;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic            MisalignF;

  modport slave (
    input  Branch, Jump, TargetE, StallF, InstrF,
    output PCF, InstrD, PCD, PCPlus4D, ValidD, RedirectCnt, MisalignF
  );
  modport master (
    output Branch, Jump, TargetE, StallF, InstrF,
    input  PCF, InstrD, PCD, PCPlus4D, ValidD, RedirectCnt, MisalignF
  );
`else
  modport slave (
    input  Branch, Jump, TargetE, StallF, InstrF,
    output PCF, InstrD, PCD, PCPlus4D, ValidD, RedirectCnt
  );
  modport master (
    output Branch, Jump, TargetE, StallF, InstrF,
    input  PCF, InstrD, PCD, PCPlus4D, ValidD, RedirectCnt
  );
`endif
endinterface

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - instruction fetch stage: PC register, next-PC select, IF/ID latch
// Purpose: owns the PC, fetches from imem at PCF, registers IF/ID, and squashes the
//   wrong-path fetch on a redirect (Branch | Jump) from EX.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   fif   - fetch_pc_if.slave: Branch, Jump, TargetE, StallF, InstrF in;
//           PCF, InstrD, PCD, PCPlus4D, ValidD, RedirectCnt (and MisalignF) out
// Optional: FETCH_MISALIGN_TRAP_EN - misaligned redirect targets freeze the PC and
//   raise MisalignF; otherwise the low two target bits are dropped.
module fetch_pc_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic     clk,
  input  logic     reset,
  fetch_pc_if.slave fif
);
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h00000013);

  typedef enum logic [1:0] {BOOT, RUN, SQUASH} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pcd_q, pcd_d;
  logic [XLEN-1:0] pc4d_q, pc4d_d;
  logic            valid_q, valid_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            redirect;
  logic [XLEN-1:0] pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic            mis_q, mis_d;
`endif

  assign redirect = fif.Branch | fif.Jump;
  assign pc_plus4 = pc_q + XLEN'(4);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pc4d_d  = pc4d_q;
    valid_d = valid_q;
    cnt_d   = (redirect && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    mis_d   = mis_q;
    if (mis_q) begin
      // Trapped: PC frozen, decode sees only bubbles until reset.
      instr_d = NOP;
      valid_d = 1'b0;
    end else if (redirect && fif.TargetE[1:0] != 2'b00) begin
      instr_d = NOP;
      valid_d = 1'b0;
      mis_d   = 1'b1;
    end else
`endif
    if (redirect) begin
      // Redirect beats a stall so a resolved branch is never lost.
      pc_d    = {fif.TargetE[XLEN-1:2], 2'b00};
      instr_d = NOP;
      valid_d = 1'b0;
      state_d = SQUASH;
    end else if (!fif.StallF) begin
      // BOOT, RUN and SQUASH all capture the current fetch and move on;
      // in SQUASH this is the target instruction arriving.
      pc_d    = pc_plus4;
      instr_d = fif.InstrF;
      pcd_d   = pc_q;
      pc4d_d  = pc_plus4;
      valid_d = 1'b1;
      case (state_q)
        BOOT, RUN, SQUASH: state_d = RUN;
        default:           state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      pcd_q   <= '0;
      pc4d_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pc4d_q  <= pc4d_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign fif.PCF         = pc_q;
  assign fif.InstrD      = instr_q;
  assign fif.PCD         = pcd_q;
  assign fif.PCPlus4D    = pc4d_q;
  assign fif.ValidD      = valid_q;
  assign fif.RedirectCnt = cnt_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign fif.MisalignF   = mis_q;
`endif
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  fetch_pc_if #(.XLEN(32)) fif ();

  // imem model: instruction word is the bitwise inverse of its address
  assign fif.InstrF = ~fif.PCF;

  fetch_pc_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .reset(reset),
    .fif(fif)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    fif.Branch = 0; fif.Jump = 0; fif.StallF = 0; fif.TargetE = 0;
    reset = 1; step(); step(); reset = 0;
    checks++; if (fif.PCF !== 32'h0) begin errors++; $display("FAIL reset_pcf got %h exp %h", fif.PCF, 32'h0); end
    checks++; if (fif.InstrD !== 32'h13) begin errors++; $display("FAIL reset_instrd got %h exp %h", fif.InstrD, 32'h13); end
    checks++; if (fif.ValidD !== 1'b0) begin errors++; $display("FAIL reset_validd got %b exp 0", fif.ValidD); end
    checks++; if (fif.RedirectCnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", fif.RedirectCnt); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    for (int i = 1; i <= 4; i++) begin
      step();
      exp_pc = 32'(i * 4);
      checks++; if (fif.PCF !== exp_pc) begin errors++; $display("FAIL seq_pcf[%0d] got %h exp %h", i, fif.PCF, exp_pc); end
      checks++; if (fif.PCD !== exp_pc - 4) begin errors++; $display("FAIL seq_pcd[%0d] got %h exp %h", i, fif.PCD, exp_pc - 4); end
      checks++; if (fif.InstrD !== ~(exp_pc - 4)) begin errors++; $display("FAIL seq_instrd[%0d] got %h exp %h", i, fif.InstrD, ~(exp_pc - 4)); end
      checks++; if (fif.ValidD !== 1'b1) begin errors++; $display("FAIL seq_validd[%0d] got %b exp 1", i, fif.ValidD); end
    end
  endtask

  task automatic test_branch();
    // PCF is 0x10 here
    fif.Branch = 1; fif.TargetE = 32'h40; step(); fif.Branch = 0;
    checks++; if (fif.PCF !== 32'h40) begin errors++; $display("FAIL br_pcf got %h exp %h", fif.PCF, 32'h40); end
    checks++; if (fif.ValidD !== 1'b0) begin errors++; $display("FAIL br_bubble got %b exp 0", fif.ValidD); end
    checks++; if (fif.InstrD !== 32'h13) begin errors++; $display("FAIL br_nop got %h exp %h", fif.InstrD, 32'h13); end
    step();
    checks++; if (fif.PCD !== 32'h40) begin errors++; $display("FAIL br_pcd got %h exp %h", fif.PCD, 32'h40); end
    checks++; if (fif.ValidD !== 1'b1) begin errors++; $display("FAIL br_valid got %b exp 1", fif.ValidD); end
    checks++; if (fif.InstrD !== ~32'h40) begin errors++; $display("FAIL br_instrd got %h exp %h", fif.InstrD, ~32'h40); end
    checks++; if (fif.PCF !== 32'h44) begin errors++; $display("FAIL br_pcf2 got %h exp %h", fif.PCF, 32'h44); end
    checks++; if (fif.RedirectCnt !== 16'd1) begin errors++; $display("FAIL br_cnt got %0d exp 1", fif.RedirectCnt); end
  endtask

  task automatic test_stall();
    fif.Jump = 1; fif.TargetE = 32'h18; step(); fif.Jump = 0;
    step(); step();
    checks++; if (fif.PCF !== 32'h20) begin errors++; $display("FAIL st_setup got %h exp %h", fif.PCF, 32'h20); end
    fif.StallF = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (fif.PCF !== 32'h20) begin errors++; $display("FAIL st_pcf[%0d] got %h exp %h", i, fif.PCF, 32'h20); end
      checks++; if (fif.PCD !== 32'h1c) begin errors++; $display("FAIL st_pcd[%0d] got %h exp %h", i, fif.PCD, 32'h1c); end
      checks++; if (fif.InstrD !== ~32'h1c) begin errors++; $display("FAIL st_instrd[%0d] got %h exp %h", i, fif.InstrD, ~32'h1c); end
      checks++; if (fif.ValidD !== 1'b1) begin errors++; $display("FAIL st_valid[%0d] got %b exp 1", i, fif.ValidD); end
    end
    fif.StallF = 0; step();
    checks++; if (fif.PCF !== 32'h24) begin errors++; $display("FAIL st_release got %h exp %h", fif.PCF, 32'h24); end
    checks++; if (fif.PCD !== 32'h20) begin errors++; $display("FAIL st_release_pcd got %h exp %h", fif.PCD, 32'h20); end
    checks++; if (fif.RedirectCnt !== 16'd2) begin errors++; $display("FAIL st_cnt got %0d exp 2", fif.RedirectCnt); end
  endtask

  task automatic test_stall_jump();
    fif.StallF = 1; fif.Jump = 1; fif.TargetE = 32'h80; step(); fif.StallF = 0; fif.Jump = 0;
    checks++; if (fif.PCF !== 32'h80) begin errors++; $display("FAIL sj_pcf got %h exp %h", fif.PCF, 32'h80); end
    checks++; if (fif.ValidD !== 1'b0) begin errors++; $display("FAIL sj_bubble got %b exp 0", fif.ValidD); end
    checks++; if (fif.RedirectCnt !== 16'd3) begin errors++; $display("FAIL sj_cnt got %0d exp 3", fif.RedirectCnt); end
    step();
    checks++; if (fif.PCD !== 32'h80 || fif.ValidD !== 1'b1) begin errors++; $display("FAIL sj_target pcd %h valid %b exp 80 1", fif.PCD, fif.ValidD); end
  endtask

  task automatic test_back_to_back();
    reset = 1; step(); reset = 0; step();
    checks++; if (fif.PCF !== 32'h4) begin errors++; $display("FAIL b2b_boot got %h exp %h", fif.PCF, 32'h4); end
    fif.Branch = 1; fif.TargetE = 32'h100; step();
    checks++; if (fif.PCF !== 32'h100 || fif.ValidD !== 1'b0) begin errors++; $display("FAIL b2b_first pcf %h valid %b exp 100 0", fif.PCF, fif.ValidD); end
    fif.TargetE = 32'h200; step(); fif.Branch = 0;
    checks++; if (fif.PCF !== 32'h200 || fif.ValidD !== 1'b0) begin errors++; $display("FAIL b2b_second pcf %h valid %b exp 200 0", fif.PCF, fif.ValidD); end
    checks++; if (fif.RedirectCnt !== 16'd2) begin errors++; $display("FAIL b2b_cnt got %0d exp 2", fif.RedirectCnt); end
    step();
    checks++; if (fif.PCD !== 32'h200 || fif.ValidD !== 1'b1) begin errors++; $display("FAIL b2b_target pcd %h valid %b exp 200 1", fif.PCD, fif.ValidD); end
    checks++; if (fif.PCF !== 32'h204) begin errors++; $display("FAIL b2b_next got %h exp %h", fif.PCF, 32'h204); end
  endtask

  task automatic test_wrap_and_align();
    fif.Jump = 1; fif.TargetE = 32'hFFFFFFFC; step(); fif.Jump = 0;
    step();
    checks++; if (fif.PCF !== 32'h0) begin errors++; $display("FAIL wrap_pcf got %h exp 0", fif.PCF); end
    checks++; if (fif.PCD !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_pcd got %h exp fffffffc", fif.PCD); end
    checks++; if (fif.PCPlus4D !== 32'h0) begin errors++; $display("FAIL wrap_pc4d got %h exp 0", fif.PCPlus4D); end
    step();
    fif.Branch = 1; fif.TargetE = 32'h42; step(); fif.Branch = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
    checks++; if (fif.PCF !== 32'h4) begin errors++; $display("FAIL mis_hold got %h exp 4", fif.PCF); end
    checks++; if (fif.MisalignF !== 1'b1) begin errors++; $display("FAIL mis_flag got %b exp 1", fif.MisalignF); end
    step(); step();
    checks++; if (fif.PCF !== 32'h4 || fif.ValidD !== 1'b0) begin errors++; $display("FAIL mis_frozen pcf %h valid %b exp 4 0", fif.PCF, fif.ValidD); end
`else
    checks++; if (fif.PCF !== 32'h40) begin errors++; $display("FAIL align_pcf got %h exp 40", fif.PCF); end
    checks++; if (fif.ValidD !== 1'b0) begin errors++; $display("FAIL align_bubble got %b exp 0", fif.ValidD); end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_stall_jump();
    test_back_to_back();
    test_wrap_and_align();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
